mux_arb_438: RTL and testbench
==============================

# mux_arb_438

Two-requester round-robin arbiter that owns the quad 2-to-1 multiplexer with active-high output disable (`circ_438`) and shares its 4-bit output bus `mout` between source A and source B. It drives the mux's `enb` and `sel` from a registered grant state machine. It limits each grant to a bounded burst of beats so that neither requester can starve the other. It sits between the two data sources and the downstream consumer of `mout`.

## Interface
- `BURST`, default 4: maximum consecutive beats per grant while the other side is waiting; legal range 1..8.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_a` in 1: source A requests the bus; level-sensitive; held while it has data.
- `req_b` in 1: source B requests the bus; level-sensitive.
- `A` in 4: source A data.
- `B` in 4: source B data.
- `mout` out 4: muxed bus. Equals `A` when A is granted, `B` when B is granted, and 4'b0000 otherwise.
- `gnt_a` out 1: registered; A owns the bus this cycle.
- `gnt_b` out 1: registered; B owns the bus this cycle.
- `busy` out 1: registered; equals `gnt_a | gnt_b`.

## Operation
- **States:** IDLE, GNT_A, GNT_B.
- **Internal registers:**
  - `last`: 1 bit; 0 means A was served last, 1 means B was served last.
  - `cnt`: 3-bit beat counter.
- **Mux drive by state:**
  - IDLE: `enb`=1, `sel`=0, so `mout`=0000.
  - GNT_A: `enb`=0, `sel`=0.
  - GNT_B: `enb`=0, `sel`=1.
- **IDLE transitions:**
  - Only `req_a` asserted: go to GNT_A.
  - Only `req_b` asserted: go to GNT_B.
  - Both asserted: grant the side not equal to `last`.
  - Neither asserted: stay in IDLE.
  - On entering any grant state, `cnt` is cleared to 0.
- **GNT_X transitions (X is the owner, Y is the other side), evaluated in priority order:**
  - `req_x`=0 and `req_y`=1: go to GNT_Y; `cnt`←0; `last`←X.
  - `req_x`=0 and `req_y`=0: go to IDLE; `last`←X.
  - `req_x`=1 and `cnt`=BURST-1 and `req_y`=1: go to GNT_Y; `cnt`←0; `last`←X. This is the forced hand-over.
  - `req_x`=1 and `cnt`=BURST-1 and `req_y`=0: stay in GNT_X; `cnt`←0, so the burst restarts.
  - Otherwise: stay in GNT_X; `cnt`←`cnt`+1.
- **Hand-over:** GNT_A to GNT_B (and back) happens directly, with no IDLE bubble.
- **BURST=1:** a grant lasts exactly one beat whenever the other side is requesting, giving strict alternation.
- **Onehot invariant:** `gnt_a` and `gnt_b` are never both 1. `busy`=0 exactly when the state is IDLE.

## Timing
- **Reset values while `rst`=1:**
  - State IDLE, `last`=1, `cnt`=0.
  - `gnt_a`=0, `gnt_b`=0, `busy`=0.
  - Internal `enb`=1, `sel`=0, so `mout`=0000.
  - Because `last`=1, A wins the first contested arbitration.
- **Reset mid-grant:** grant outputs drop and `mout` forces to 0000 immediately (asynchronously), with no clock edge needed.
- **Reset release:** the first arbitration decision is taken on the first rising edge after `rst` deasserts.
- **Request-to-grant latency:** 1 cycle. A request sampled at edge N produces `gnt`, `sel` and `enb` valid after edge N.
- **Data path:** `mout` is combinational from the registered `sel`/`enb` and the live `A`/`B` inputs. There is no data register, so data latency is 0 cycles.
- **Beat definition:** one cycle with the grant asserted. Under continuous contention each side holds the bus exactly BURST cycles.
- **Request drop:** a requester that drops its request loses the grant at the next edge. It may receive at most one extra granted cycle after deassertion; the source must tolerate this.

## Structure
- **Shared defines include:**
  - State encodings: IDLE=2'b00, GNT_A=2'b01, GNT_B=2'b10.
  - `last` encoding.
  - Default `BURST`.
  - The bench includes this file as well.
- **Sub-module:** exactly one instance of `circ_438`. Its `enb` and `sel` come from the controller registers, its `A`/`B` inputs from the top-level inputs, and its `mout` drives the top-level `mout`.
- **Remaining logic:** the FSM, counter and `last` logic live in the top module. No other sub-modules.

## Test plan
1. **Reset behaviour:** `rst`=1 for 3 cycles with `req_a`=`req_b`=1, A=0001, B=0010 → `mout`=0000, `gnt_a`=`gnt_b`=0. After release, `gnt_a`=1 and `mout`=0001 after the first edge.
2. **Single requester:** only `req_b`=1 for 10 cycles, B=1010 → `gnt_b`=1 continuously from cycle 1 with no hand-over, `mout`=1010. After `req_b` drops, state returns to IDLE and `mout`=0000.
3. **Contention, BURST=4:** both requesting continuously, A=0001, B=0010 → `mout` shows 0001 for 4 cycles, then 0010 for 4 cycles, repeating. No idle gap at hand-overs.
4. **Early drop:** A granted, `req_a` drops after 2 beats while `req_b`=1 → `gnt_b` asserts the next edge and the burst counter restarts for B.
5. **Reset mid-grant:** `rst` pulses during GNT_B → `gnt_b` and `mout` go to 0 without a clock edge. After release with both requesting, A is granted first.
6. **BURST=1:** both requesting → `gnt_a`/`gnt_b` alternate every cycle. Onehot assertion holds throughout all scenarios.

Source files
------------

// File: rtl/mux_arb_438_pkg.sv
// rtl/mux_arb_438_pkg.sv - shared state, last-served encodings and defaults for mux_arb_438
package mux_arb_438_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } state_t;

    // Which side was served most recently; the other side wins a tie.
    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_t;

    localparam int BURST_DEFAULT = 4;

endpackage

// File: rtl/mux_arb_438_if.sv
// rtl/mux_arb_438_if.sv - request/data/grant bundle between sources, arbiter and consumer
interface mux_arb_438_if;
    logic       req_a;
    logic       req_b;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] mout;
    logic       gnt_a;
    logic       gnt_b;
    logic       busy;

    // Sources and consumer side
    modport master (
        output req_a, req_b, A, B,
        input  mout, gnt_a, gnt_b, busy
    );

    // Arbiter side
    modport slave (
        input  req_a, req_b, A, B,
        output mout, gnt_a, gnt_b, busy
    );
endinterface

// File: rtl/mux_arb_438_circ.sv
// rtl/mux_arb_438_circ.sv - quad 2-to-1 multiplexer with active-high output disable
module circ_438 (
    input  logic       enb,
    input  logic       sel,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] mout
);
    // Disabled outputs read as zero; otherwise sel picks B over A.
    always_comb begin
        mout = 4'b0000;
        if (!enb) begin
            mout = sel ? B : A;
        end
    end
endmodule

// File: rtl/mux_arb_438.sv
// rtl/mux_arb_438.sv - round-robin two-source arbiter owning a quad 2-to-1 output mux
module mux_arb_438
    import mux_arb_438_pkg::*;
#(
    parameter int BURST = BURST_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    mux_arb_438_if.slave  bus
);

    localparam logic [2:0] CNT_LAST = 3'(BURST - 1);

    state_t     state_q, state_d;
    last_t      last_q, last_d;
    logic [2:0] cnt_q, cnt_d;

    logic enb_q, sel_q, gnt_a_q, gnt_b_q, busy_q;
    logic enb_d, sel_d, gnt_a_d, gnt_b_d, busy_d;

    // Owner-relative view of the requests so both grant states share one rule set.
    logic   req_own, req_oth;
    state_t st_oth;
    last_t  last_own;

    // State, counter, last-served and registered mux/grant outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= LAST_B;
            cnt_q   <= 3'd0;
            enb_q   <= 1'b1;
            sel_q   <= 1'b0;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            enb_q   <= enb_d;
            sel_q   <= sel_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: round-robin on ties, bounded bursts, direct hand-over.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        req_own  = (state_q == GNT_B) ? bus.req_b : bus.req_a;
        req_oth  = (state_q == GNT_B) ? bus.req_a : bus.req_b;
        st_oth   = (state_q == GNT_B) ? GNT_A : GNT_B;
        last_own = (state_q == GNT_B) ? LAST_B : LAST_A;
        case (state_q)
            IDLE: begin
                if (bus.req_a && (!bus.req_b || last_q == LAST_B)) begin
                    state_d = GNT_A;
                    cnt_d   = 3'd0;
                end else if (bus.req_b) begin
                    state_d = GNT_B;
                    cnt_d   = 3'd0;
                end
            end
            GNT_A, GNT_B: begin
                if (!req_own) begin
                    last_d  = last_own;
                    state_d = req_oth ? st_oth : IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q == CNT_LAST) begin
                    // Burst exhausted: yield if the other side waits, else restart.
                    cnt_d = 3'd0;
                    if (req_oth) begin
                        state_d = st_oth;
                        last_d  = last_own;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Output decode of the next state so grants and mux controls leave a flop.
    always_comb begin
        enb_d   = 1'b1;
        sel_d   = 1'b0;
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        case (state_d)
            GNT_A: begin
                enb_d   = 1'b0;
                gnt_a_d = 1'b1;
            end
            GNT_B: begin
                enb_d   = 1'b0;
                sel_d   = 1'b1;
                gnt_b_d = 1'b1;
            end
            default: begin
                enb_d = 1'b1;
            end
        endcase
        busy_d = gnt_a_d | gnt_b_d;
    end

    assign bus.gnt_a = gnt_a_q;
    assign bus.gnt_b = gnt_b_q;
    assign bus.busy  = busy_q;

    circ_438 u_circ (
        .enb  (enb_q),
        .sel  (sel_q),
        .A    (bus.A),
        .B    (bus.B),
        .mout (bus.mout)
    );

endmodule

// File: tb/tb_mux_arb_438.sv
// tb/tb_mux_arb_438.sv - randomized self-checking bench for mux_arb_438 at BURST=4 and BURST=1
module tb_mux_arb_438;
    import mux_arb_438_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       req_a, req_b;
    logic [3:0] da, db;

    mux_arb_438_if bus4 ();
    mux_arb_438_if bus1 ();

    assign bus4.req_a = req_a;
    assign bus4.req_b = req_b;
    assign bus4.A     = da;
    assign bus4.B     = db;
    assign bus1.req_a = req_a;
    assign bus1.req_b = req_b;
    assign bus1.A     = da;
    assign bus1.B     = db;

    mux_arb_438 #(.BURST(BURST_DEFAULT)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    mux_arb_438 #(.BURST(1))             dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [3:0] o_mout [2];
    logic       o_ga   [2];
    logic       o_gb   [2];
    logic       o_busy [2];
    assign o_mout[0] = bus4.mout;
    assign o_ga[0]   = bus4.gnt_a;
    assign o_gb[0]   = bus4.gnt_b;
    assign o_busy[0] = bus4.busy;
    assign o_mout[1] = bus1.mout;
    assign o_ga[1]   = bus1.gnt_a;
    assign o_gb[1]   = bus1.gnt_b;
    assign o_busy[1] = bus1.busy;

    int checks = 0;
    int errors = 0;

    // Reference model: owner 0=none 1=A 2=B; last 0=A served last, 1=B; beats held so far.
    int m_owner [2];
    int m_last  [2];
    int m_beats [2];
    int m_burst [2] = '{BURST_DEFAULT, 1};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = 0;
            m_last[k]  = 1;
            m_beats[k] = 0;
        end
    endtask

    task automatic model_step();
        int rx, ry;
        for (int k = 0; k < 2; k++) begin
            if (m_owner[k] == 0) begin
                if (req_a && req_b) begin
                    m_owner[k] = (m_last[k] == 1) ? 1 : 2;
                    m_beats[k] = 1;
                end else if (req_a) begin
                    m_owner[k] = 1;
                    m_beats[k] = 1;
                end else if (req_b) begin
                    m_owner[k] = 2;
                    m_beats[k] = 1;
                end
            end else begin
                rx = (m_owner[k] == 1) ? int'(req_a) : int'(req_b);
                ry = (m_owner[k] == 1) ? int'(req_b) : int'(req_a);
                if (rx == 0) begin
                    m_last[k]  = m_owner[k] - 1;
                    m_owner[k] = (ry != 0) ? 3 - m_owner[k] : 0;
                    m_beats[k] = 1;
                end else if (m_beats[k] >= m_burst[k]) begin
                    if (ry != 0) begin
                        m_last[k]  = m_owner[k] - 1;
                        m_owner[k] = 3 - m_owner[k];
                    end
                    m_beats[k] = 1;
                end else begin
                    m_beats[k] = m_beats[k] + 1;
                end
            end
        end
    endtask

    function automatic logic [3:0] exp_mout(int k);
        if (m_owner[k] == 1) return da;
        if (m_owner[k] == 2) return db;
        return 4'b0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic cyc(input logic ra, input logic rb, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        req_a = ra;
        req_b = rb;
        da    = a;
        db    = b;
        tick();
    endtask

    // Onehot and busy invariants watched continuously, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ((o_ga[k] && o_gb[k]) || (o_busy[k] !== (o_ga[k] | o_gb[k]))) begin
                    errors++;
                    $display("FAIL onehot dut%0d: gnt_a=%b gnt_b=%b busy=%b", k, o_ga[k], o_gb[k], o_busy[k]);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, 1'b1, 4'b0001, 4'b0010);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_mout[k] !== 4'b0000 || o_ga[k] !== 1'b0 || o_gb[k] !== 1'b0 || o_busy[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_hold dut%0d: mout=%b gnt_a=%b gnt_b=%b busy=%b want 0000/0/0/0",
                             k, o_mout[k], o_ga[k], o_gb[k], o_busy[k]);
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_ga[k] !== 1'b1 || o_gb[k] !== 1'b0 || o_mout[k] !== 4'b0001) begin
                errors++;
                $display("FAIL reset_release dut%0d: gnt_a=%b gnt_b=%b mout=%b want 1/0/0001",
                         k, o_ga[k], o_gb[k], o_mout[k]);
            end
        end
    endtask

    task automatic test_single_requester();
        for (int c = 0; c < 10; c++) begin
            cyc(1'b0, 1'b1, 4'($urandom), 4'b1010);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_gb[k] !== 1'b1 || o_ga[k] !== 1'b0 || o_mout[k] !== 4'b1010) begin
                    errors++;
                    $display("FAIL single_b dut%0d cyc%0d: gnt_a=%b gnt_b=%b mout=%b want 0/1/1010",
                             k, c, o_ga[k], o_gb[k], o_mout[k]);
                end
            end
        end
        for (int c = 0; c < 2; c++) begin
            cyc(1'b0, 1'b0, 4'($urandom), 4'($urandom));
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_mout[k] !== 4'b0000 || o_busy[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL single_drop dut%0d: mout=%b busy=%b want 0000/0", k, o_mout[k], o_busy[k]);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic prev_ga1;
        prev_ga1 = 1'bx;
        for (int c = 0; c < 24; c++) begin
            cyc(1'b1, 1'b1, 4'($urandom), 4'($urandom));
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_mout[k] !== exp_mout(k) || o_ga[k] !== (m_owner[k] == 1) || o_gb[k] !== (m_owner[k] == 2)
                    || o_busy[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL contention dut%0d cyc%0d: mout=%b gnt_a=%b gnt_b=%b want mout=%b owner=%0d",
                             k, c, o_mout[k], o_ga[k], o_gb[k], exp_mout(k), m_owner[k]);
                end
            end
            if (c > 0) begin
                checks++;
                if (o_ga[1] === prev_ga1) begin
                    errors++;
                    $display("FAIL burst1_alternate cyc%0d: gnt_a=%b previous=%b want toggle", c, o_ga[1], prev_ga1);
                end
            end
            prev_ga1 = o_ga[1];
        end
    endtask

    task automatic test_early_drop();
        cyc(1'b0, 1'b0, 4'h0, 4'h0);
        cyc(1'b0, 1'b0, 4'h0, 4'h0);
        cyc(1'b1, 1'b0, 4'h3, 4'hc);
        cyc(1'b1, 1'b1, 4'h3, 4'hc);
        cyc(1'b0, 1'b1, 4'h3, 4'hc);
        checks++;
        if (o_gb[0] !== 1'b1 || o_mout[0] !== 4'hc) begin
            errors++;
            $display("FAIL early_drop_handover: gnt_b=%b mout=%b want 1/1100", o_gb[0], o_mout[0]);
        end
        for (int c = 0; c < 6; c++) begin
            cyc(1'b1, 1'b1, 4'($urandom), 4'($urandom));
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_mout[k] !== exp_mout(k) || o_ga[k] !== (m_owner[k] == 1) || o_gb[k] !== (m_owner[k] == 2)) begin
                    errors++;
                    $display("FAIL early_drop dut%0d cyc%0d: mout=%b gnt_a=%b gnt_b=%b want mout=%b owner=%0d",
                             k, c, o_mout[k], o_ga[k], o_gb[k], exp_mout(k), m_owner[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        cyc(1'b0, 1'b1, 4'h5, 4'h9);
        cyc(1'b0, 1'b1, 4'h5, 4'h9);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_gb[k] !== 1'b0 || o_ga[k] !== 1'b0 || o_mout[k] !== 4'b0000) begin
                errors++;
                $display("FAIL reset_async dut%0d: gnt_a=%b gnt_b=%b mout=%b want 0/0/0000",
                         k, o_ga[k], o_gb[k], o_mout[k]);
            end
        end
        @(negedge clk);
        rst   = 1'b0;
        req_a = 1'b1;
        req_b = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_ga[k] !== 1'b1 || o_mout[k] !== 4'h5) begin
                errors++;
                $display("FAIL reset_mid_rearb dut%0d: gnt_a=%b mout=%b want 1/0101", k, o_ga[k], o_mout[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom));
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_mout[k] !== exp_mout(k) || o_ga[k] !== (m_owner[k] == 1) || o_gb[k] !== (m_owner[k] == 2)) begin
                    errors++;
                    $display("FAIL random dut%0d cyc%0d: mout=%b gnt_a=%b gnt_b=%b want mout=%b owner=%0d",
                             k, c, o_mout[k], o_ga[k], o_gb[k], exp_mout(k), m_owner[k]);
                end
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        da    = 4'h0;
        db    = 4'h0;
        model_reset();
        test_reset();
        test_single_requester();
        test_contention();
        test_early_drop();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
